// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants, state encoding and helpers for the UART command parser.
// Host-side tools use the same byte values.
package uart_cmd_parser_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WR    = 8'h01;
    localparam logic [7:0] CMD_RD    = 8'h02;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CHK,
        ST_EXEC,
        ST_RD_WAIT,
        ST_TX
    } state_t;

    function automatic logic is_known_cmd(input logic [7:0] cmd);
        return (cmd == CMD_WR) || (cmd == CMD_RD);
    endfunction

    // States in which the inter-byte timeout is armed.
    function automatic logic in_frame(input state_t s);
        return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/uart_timeout_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear and
// flags expiry on the cycle the count reaches TIMEOUT_CYC-1.
module uart_timeout_timer #(
    parameter int TIMEOUT_CYC = 104160
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expire = enable && (cnt == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_cmd_parser.sv
// Turns received UART bytes into framed register commands (SYNC CMD ADDR DATA CHK)
// and queues one reply byte (ACK, NAK or read data) for the transmitter.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int CLK_FREQ    = 50000000,
    parameter int UART_BPS    = 9600,
    parameter int TIMEOUT_CYC = CLK_FREQ / UART_BPS * 20
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_done,
    input  logic [7:0] uart_data,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wr_data,
    input  logic [7:0] reg_rd_data,
    output logic       tx_en,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       frame_err,
    output logic [7:0] err_cnt
);

    state_t     state, state_nxt;
    logic       uart_done_q;
    logic       byte_stb;
    logic [7:0] cmd_q, addr_q, data_q, xsum_q, reply_q;
    logic       rd_capture;
    logic       tmr_en, tmr_clear, tmr_expire;
    logic       wr_en_d, rd_en_d, tx_en_d, err_d, reply_ld;
    logic [7:0] reply_d, tx_src;

    assign byte_stb  = uart_done & ~uart_done_q;
    assign tmr_en    = in_frame(state);
    assign tmr_clear = byte_stb | ~tmr_en;

    // Read data arrives the cycle after the strobe; forward it straight to the transmitter.
    assign tx_src = rd_capture ? reg_rd_data : reply_q;

    assign reg_addr    = addr_q;
    assign reg_wr_data = data_q;

    uart_timeout_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expire  (tmr_expire)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        tx_en_d   = 1'b0;
        err_d     = 1'b0;
        reply_ld  = 1'b0;
        reply_d   = ACK_BYTE;

        case (state)
            ST_IDLE: begin
                if (byte_stb && (uart_data == SYNC_BYTE)) state_nxt = ST_CMD;
            end
            ST_CMD, ST_ADDR, ST_DATA: begin
                if (byte_stb) begin
                    state_nxt = state_t'(state + 3'd1);
                end else if (tmr_expire) begin
                    state_nxt = ST_IDLE;
                    err_d     = 1'b1;
                end
            end
            ST_CHK: begin
                // A byte arriving on the expiry cycle still completes the frame.
                if (byte_stb) begin
                    if ((uart_data != xsum_q) || !is_known_cmd(cmd_q)) begin
                        state_nxt = ST_TX;
                        err_d     = 1'b1;
                        reply_ld  = 1'b1;
                        reply_d   = NAK_BYTE;
                    end else begin
                        state_nxt = ST_EXEC;
                    end
                end else if (tmr_expire) begin
                    state_nxt = ST_IDLE;
                    err_d     = 1'b1;
                end
            end
            ST_EXEC: begin
                if (cmd_q == CMD_WR) begin
                    wr_en_d   = 1'b1;
                    reply_ld  = 1'b1;
                    reply_d   = ACK_BYTE;
                    state_nxt = ST_TX;
                end else begin
                    rd_en_d   = 1'b1;
                    state_nxt = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                state_nxt = ST_TX;
            end
            ST_TX: begin
                if (!tx_busy) begin
                    tx_en_d   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            uart_done_q <= 1'b0;
            cmd_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            xsum_q      <= '0;
            reply_q     <= '0;
            rd_capture  <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            tx_en       <= 1'b0;
            tx_data     <= '0;
            frame_err   <= 1'b0;
            err_cnt     <= '0;
        end else begin
            uart_done_q <= uart_done;
            if (byte_stb) begin
                case (state)
                    ST_CMD:  begin cmd_q  <= uart_data; xsum_q <= uart_data;          end
                    ST_ADDR: begin addr_q <= uart_data; xsum_q <= xsum_q ^ uart_data; end
                    ST_DATA: begin data_q <= uart_data; xsum_q <= xsum_q ^ uart_data; end
                    default: ;
                endcase
            end

            rd_capture <= reg_rd_en;
            if (rd_capture) begin
                reply_q <= reg_rd_data;
            end else if (reply_ld) begin
                reply_q <= reply_d;
            end

            reg_wr_en <= wr_en_d;
            reg_rd_en <= rd_en_d;
            tx_en     <= tx_en_d;
            if (tx_en_d) tx_data <= tx_src;

            frame_err <= err_d;
            if (err_d && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: a frame-level reference model
// predicts strobes, replies and errors cycle by cycle; directed cases pin it.
module tb_uart_cmd_parser;

    localparam int CLK_FREQ = 1_920_000;
    localparam int UART_BPS = 9600;
    localparam int TMO      = CLK_FREQ / UART_BPS * 20;

    logic       sys_clk;
    logic       sys_rst;
    logic       uart_done;
    logic [7:0] uart_data;
    logic       reg_wr_en, reg_rd_en;
    logic [7:0] reg_addr, reg_wr_data, reg_rd_data;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       frame_err;
    logic [7:0] err_cnt;

    uart_cmd_parser #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .uart_done   (uart_done),
        .uart_data   (uart_data),
        .reg_wr_en   (reg_wr_en),
        .reg_rd_en   (reg_rd_en),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_data (reg_rd_data),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .frame_err   (frame_err),
        .err_cnt     (err_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef enum int {M_IDLE, M_COLLECT, M_BUSY} mmode_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    // reference model state
    mmode_t     mode = M_IDLE;
    logic [7:0] f [4];
    int         nf = 0;
    int         last_stb = 0;
    bit         done_prev = 0;
    bit         busy_prev = 0;
    int         exp_wr_at = -1, exp_rd_at = -1, exp_err_at = -1;
    logic [7:0] exp_addr, exp_data;
    bit         reply_pend = 0;
    int         reply_at = 0;
    logic [7:0] reply_val;
    int         model_errs = 0;
    logic [7:0] mem [256];
    bit         written [256];

    // register-file side of the bus
    bit         rd_pend = 0;
    logic [7:0] rd_addr;
    bit         rand_busy = 0;

    // observed activity
    int         n_wr = 0, n_rd = 0, n_tx = 0, n_err = 0;
    int         s_wr, s_rd, s_tx, s_err;
    logic [7:0] last_wr_addr, last_wr_data, last_tx;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 25)
                $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rd_value(input logic [7:0] a);
        return written[a] ? mem[a] : (a ^ 8'h5E);
    endfunction

    task automatic model_step();
        bit         stb;
        bit         tx_exp;
        logic [7:0] c, a, d, k;
        cyc++;
        if (sys_rst) begin
            check("rst_strobes", 32'({reg_wr_en, reg_rd_en, tx_en, frame_err}), 32'd0);
            check("rst_bus", {reg_addr, reg_wr_data, tx_data, err_cnt}, 32'd0);
            mode = M_IDLE; nf = 0; done_prev = 0; busy_prev = tx_busy;
            exp_wr_at = -1; exp_rd_at = -1; exp_err_at = -1;
            reply_pend = 0; model_errs = 0; rd_pend = 0;
            return;
        end

        tx_exp = (mode == M_BUSY) && reply_pend && (cyc >= reply_at) && !busy_prev;
        check("reg_wr_en", 32'(reg_wr_en), 32'(cyc == exp_wr_at));
        check("reg_rd_en", 32'(reg_rd_en), 32'(cyc == exp_rd_at));
        check("tx_en", 32'(tx_en), 32'(tx_exp));
        check("frame_err", 32'(frame_err), 32'(cyc == exp_err_at));
        if (cyc == exp_err_at && model_errs < 255) model_errs++;
        check("err_cnt", 32'(err_cnt), 32'(model_errs));

        if (reg_wr_en) begin
            if (cyc == exp_wr_at) begin
                check("wr_addr", 32'(reg_addr), 32'(exp_addr));
                check("wr_data", 32'(reg_wr_data), 32'(exp_data));
            end
            n_wr++; last_wr_addr = reg_addr; last_wr_data = reg_wr_data;
        end
        rd_pend = reg_rd_en;
        if (reg_rd_en) begin
            if (cyc == exp_rd_at) check("rd_addr", 32'(reg_addr), 32'(exp_addr));
            n_rd++; rd_addr = reg_addr;
        end
        if (tx_en) begin
            if (tx_exp) check("tx_data", 32'(tx_data), 32'(reply_val));
            n_tx++; last_tx = tx_data;
        end
        if (frame_err) n_err++;
        if (tx_exp) begin
            mode = M_IDLE;
            reply_pend = 0;
        end

        stb = uart_done && !done_prev;
        done_prev = uart_done;
        if (stb) begin
            case (mode)
                M_IDLE: if (uart_data == 8'hA5) begin
                    mode = M_COLLECT; nf = 0; last_stb = cyc;
                end
                M_COLLECT: begin
                    f[nf] = uart_data; nf++; last_stb = cyc;
                    if (nf == 4) begin
                        c = f[0]; a = f[1]; d = f[2]; k = f[3];
                        mode = M_BUSY; reply_pend = 1;
                        if (k != (c ^ a ^ d) || !(c == 8'h01 || c == 8'h02)) begin
                            exp_err_at = cyc + 1; reply_val = 8'h15; reply_at = cyc + 2;
                        end else if (c == 8'h01) begin
                            exp_wr_at = cyc + 2; exp_addr = a; exp_data = d;
                            mem[a] = d; written[a] = 1;
                            reply_val = 8'h06; reply_at = cyc + 3;
                        end else begin
                            exp_rd_at = cyc + 2; exp_addr = a;
                            reply_val = rd_value(a); reply_at = cyc + 4;
                        end
                    end
                end
                default: ;
            endcase
        end else if (mode == M_COLLECT && (cyc - last_stb) == TMO) begin
            exp_err_at = cyc + 1;
            mode = M_IDLE;
        end
        busy_prev = tx_busy;
    endtask

    // One clock: evaluate the model mid-cycle, then drive inputs just after the edge.
    task automatic tick();
        @(negedge sys_clk);
        model_step();
        @(posedge sys_clk);
        #1;
        reg_rd_data = rd_pend ? rd_value(rd_addr) : 8'($urandom);
        if (rand_busy) tx_busy = ($urandom_range(0, 3) == 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        uart_data = b;
        uart_done = 1'b1;
        repeat (hold) tick();
        uart_done = 1'b0;
        uart_data = 8'($urandom);
        repeat (gap) tick();
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                              input logic [7:0] k, input int hold, input int gap);
        send_byte(8'hA5, hold, gap);
        send_byte(c, hold, gap);
        send_byte(a, hold, gap);
        send_byte(d, hold, gap);
        send_byte(k, hold, gap);
    endtask

    task automatic snap();
        s_wr = n_wr; s_rd = n_rd; s_tx = n_tx; s_err = n_err;
    endtask

    initial begin
        logic [7:0] c, a, d, k;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            written[i] = 0;
        end
        sys_rst = 1'b0; uart_done = 1'b0; uart_data = 8'h00;
        tx_busy = 1'b0; reg_rd_data = 8'h00;
        #2 sys_rst = 1'b1;
        repeat (3) tick();
        sys_rst = 1'b0;
        tick();
        check("reset_err_cnt", 32'(err_cnt), 32'h00);
        check("reset_tx_en", 32'(tx_en), 32'h0);

        // Write with uart_done held long per byte.
        snap();
        send_frame(8'h01, 8'h10, 8'h3C, 8'h2D, 2600, 2);
        repeat (10) tick();
        check("wr_count", 32'(n_wr - s_wr), 32'd1);
        check("wr_addr_lit", 32'(last_wr_addr), 32'h10);
        check("wr_data_lit", 32'(last_wr_data), 32'h3C);
        check("wr_tx_count", 32'(n_tx - s_tx), 32'd1);
        check("wr_ack_lit", 32'(last_tx), 32'h06);

        // Read of an unwritten register returns 0x7E.
        snap();
        send_frame(8'h02, 8'h20, 8'h00, 8'h22, 3, 2);
        repeat (10) tick();
        check("rd_count", 32'(n_rd - s_rd), 32'd1);
        check("rd_reply_lit", 32'(last_tx), 32'h7E);

        // Bad checksum.
        snap();
        send_frame(8'h01, 8'h10, 8'h3C, 8'h00, 3, 2);
        repeat (10) tick();
        check("badchk_no_wr", 32'(n_wr - s_wr), 32'd0);
        check("badchk_err", 32'(n_err - s_err), 32'd1);
        check("badchk_err_cnt", 32'(err_cnt), 32'd1);
        check("badchk_nak_lit", 32'(last_tx), 32'h15);

        // Timeout after two bytes, then a good frame.
        snap();
        send_byte(8'hA5, 3, 0);
        send_byte(8'h01, 3, 0);
        repeat (TMO + 20) tick();
        check("tmo_err", 32'(n_err - s_err), 32'd1);
        check("tmo_no_tx", 32'(n_tx - s_tx), 32'd0);
        check("tmo_err_cnt", 32'(err_cnt), 32'd2);
        snap();
        send_frame(8'h01, 8'h33, 8'h44, 8'h76, 2, 1);
        repeat (10) tick();
        check("tmo_next_wr", 32'(n_wr - s_wr), 32'd1);
        check("tmo_next_ack", 32'(last_tx), 32'h06);

        // Transmitter busy holds the reply off.
        snap();
        tx_busy = 1'b1;
        send_frame(8'h01, 8'h40, 8'h99, 8'hD8, 2, 1);
        repeat (500) tick();
        check("busy_wr", 32'(n_wr - s_wr), 32'd1);
        check("busy_held", 32'(n_tx - s_tx), 32'd0);
        tx_busy = 1'b0;
        repeat (10) tick();
        check("busy_one_tx", 32'(n_tx - s_tx), 32'd1);
        check("busy_ack", 32'(last_tx), 32'h06);

        // Garbage: 55 ignored, second A5 becomes CMD.
        snap();
        send_byte(8'h55, 2, 2);
        send_byte(8'hA5, 2, 2);
        send_byte(8'hA5, 2, 2);
        send_byte(8'h01, 2, 2);
        send_byte(8'h02, 2, 2);
        send_byte(8'h03, 2, 2);
        repeat (10) tick();
        check("garbage_err", 32'(n_err - s_err), 32'd1);
        check("garbage_no_wr", 32'(n_wr - s_wr), 32'd0);
        check("garbage_nak", 32'(last_tx), 32'h15);
        check("garbage_err_cnt", 32'(err_cnt), 32'd3);

        // Reset in the middle of DATA, then read back 0x10.
        send_byte(8'hA5, 2, 1);
        send_byte(8'h01, 2, 1);
        send_byte(8'h10, 2, 1);
        sys_rst = 1'b1;
        tick();
        check("midrst_err_cnt", 32'(err_cnt), 32'h00);
        check("midrst_addr", 32'(reg_addr), 32'h00);
        repeat (2) tick();
        sys_rst = 1'b0;
        tick();
        snap();
        send_frame(8'h02, 8'h10, 8'h00, 8'h12, 2, 1);
        repeat (10) tick();
        check("midrst_rd", 32'(n_rd - s_rd), 32'd1);
        check("midrst_rd_lit", 32'(last_tx), 32'h3C);

        // Randomized traffic with a randomly busy transmitter.
        rand_busy = 1;
        for (int n = 0; n < 60; n++) begin
            int kind, hold, gap;
            kind = $urandom_range(0, 4);
            hold = $urandom_range(1, 3);
            gap  = $urandom_range(1, 4);
            a = 8'($urandom);
            d = 8'($urandom);
            case (kind)
                0: begin c = 8'h01; k = c ^ a ^ d; end
                1: begin c = 8'h02; k = c ^ a ^ d; end
                2: begin c = 8'h01; k = (c ^ a ^ d) ^ 8'($urandom_range(1, 255)); end
                3: begin c = 8'($urandom_range(3, 255)); k = c ^ a ^ d; end
                default: begin c = 8'h5A; k = 8'h00; end
            endcase
            if (kind == 4) send_byte(8'($urandom_range(0, 8'hA4)), hold, gap);
            else send_frame(c, a, d, k, hold, gap);
            repeat ($urandom_range(0, 12)) tick();
        end
        rand_busy = 0;
        tx_busy = 1'b0;
        repeat (20) tick();

        // Error counter saturates at 255.
        for (int n = 0; n < 260; n++) begin
            send_frame(8'h03, 8'h00, 8'h00, 8'h03, 1, 1);
            repeat (4) tick();
        end
        check("err_cnt_sat", 32'(err_cnt), 32'd255);
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
